// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: synchronizes RxDone, captures RxData on its rising edge,
// and serves bytes through a registered read port. Define UART_RX_FIFO_TIMEOUT_EN to add TimeoutIrq.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
`ifdef UART_RX_FIFO_TIMEOUT_EN
    , parameter logic [15:0] TIMEOUT_CYCLES = 16'd5208
`endif
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  RxDone,
    input  logic [7:0]            RxData,
    input  logic                  RdEn,
    output logic [7:0]            RdData,
    output logic                  RdValid,
    output logic                  Empty,
    output logic                  Full,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Overflow,
    input  logic                  OvfClr
`ifdef UART_RX_FIFO_TIMEOUT_EN
    , output logic                TimeoutIrq
`endif
);

    // Write path:  state      | meaning
    //              WAIT_HIGH  | sync2=0, waiting for a frame indication
    //              WRITE      | sync2=1, sync3=0, single-cycle wr_req
    //              WAIT_LOW   | sync2=1, waiting for RxDone to drop
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic            sync1, sync2, sync3;
    logic            wr_req, rd_fire, wr_fire, drop;
    logic            ptr_empty, ptr_full;
    logic [PW-1:0]   wptr, rptr;
    logic [7:0]      mem [DEPTH];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= RxDone;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign wr_req    = sync2 & ~sync3;
    assign ptr_empty = (wptr == rptr);
    assign ptr_full  = (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]) &&
                       (wptr[PW-1] != rptr[PW-1]);
    // A read in the same cycle frees the slot the full-FIFO write needs.
    assign rd_fire   = RdEn & ~ptr_empty;
    assign wr_fire   = wr_req & (~ptr_full | rd_fire);
    assign drop      = wr_req & ptr_full & ~rd_fire;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + {{DEPTH_LOG2{1'b0}}, wr_fire};
            rptr <= rptr + {{DEPTH_LOG2{1'b0}}, rd_fire};
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_fire)
            mem[wptr[DEPTH_LOG2-1:0]] <= RxData;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RdData  <= 8'h00;
            RdValid <= 1'b0;
        end else begin
            RdValid <= rd_fire;
            if (rd_fire)
                RdData <= mem[rptr[DEPTH_LOG2-1:0]];
        end
    end

    // Status flags are registered copies of the pointer state, one cycle behind.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Empty <= 1'b1;
            Full  <= 1'b0;
            Count <= '0;
        end else begin
            Empty <= ptr_empty;
            Full  <= ptr_full;
            Count <= wptr - rptr;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            Overflow <= 1'b0;
        else if (drop)
            Overflow <= 1'b1;
        else if (OvfClr)
            Overflow <= 1'b0;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0] idle_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            idle_cnt <= 16'd0;
        else if (wr_fire || rd_fire || ptr_empty)
            idle_cnt <= 16'd0;
        else if (idle_cnt != TIMEOUT_CYCLES)
            idle_cnt <= idle_cnt + 16'd1;
    end

    assign TimeoutIrq = (idle_cnt == TIMEOUT_CYCLES) & ~ptr_empty;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer that sits directly downstream of the UART receiver.
- Detects each completed-frame indication (RxDone rising edge) and captures the receiver's 8-bit RxData into a circular FIFO.
- Presents the stored bytes to the host/bus side through a registered read handshake.
- Reports occupancy, full/empty and a sticky overflow flag.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 entries)
- TIMEOUT_CYCLES, 16'd5208, Clk cycles of write inactivity before TimeoutIrq fires (optional feature only)

Ports:
- Clk  input  1  system clock
- Rst_n  input  1  asynchronous active-low reset
- RxDone  input  1  frame-complete level from the receiver (Tick-paced, not Clk-aligned)
- RxData  input  8  received byte from the receiver, stable while RxDone is high
- RdEn  input  1  host read request, one byte per cycle when asserted
- RdData  output  8  read byte, registered
- RdValid  output  1  one-cycle pulse: RdData is valid
- Empty  output  1  FIFO holds 0 entries
- Full  output  1  FIFO holds 2^DEPTH_LOG2 entries
- Count  output  DEPTH_LOG2+1  current occupancy
- Overflow  output  1  sticky: a byte was dropped
- OvfClr  input  1  clears Overflow

Behaviour:
- Reset: all flops asynchronously cleared. RdData=0, RdValid=0, Empty=1, Full=0, Count=0, Overflow=0, pointers=0, sync flops=0.
- RxDone is passed through a 2-flop synchronizer, then a rising-edge detector.
  - wr_req pulses for exactly one Clk in the cycle after the second sync flop first reads 1.
  - Total latency is 3 Clk edges from RxDone rising to the write.
  - A high level held for many cycles produces a single write.
  - RxDone must return low before another write can be generated.
- On wr_req, RxData is sampled in that same cycle and written at wptr; wptr increments.
- Pointers are DEPTH_LOG2+1 bits wide with a wrap bit.
  - Empty when wptr == rptr.
  - Full when the low bits are equal and the wrap bits differ.
  - Count = wptr - rptr, computed modulo 2^(DEPTH_LOG2+1).
  - Empty, Full and Count are registered and reflect operations of the previous cycle.
- Read:
  - RdEn while not Empty: RdData <= mem[rptr] and RdValid=1 on the next Clk; rptr increments.
  - RdEn while Empty: ignored; RdValid=0 and RdData holds its last value.
- Simultaneous wr_req and RdEn:
  - Not empty, not full: both happen; Count is unchanged.
  - Empty: only the write happens, with no read-through. The byte is readable from the next cycle.
  - Full: the read frees a slot, the write is accepted, Count stays at full.
- Overflow:
  - wr_req while Full without a concurrent valid read: the byte is dropped, the pointers are unchanged, Overflow <= 1.
  - OvfClr=1 clears Overflow.
  - If a new drop and OvfClr occur in the same cycle, the set wins.
- Reset asserted mid-operation: the FIFO contents are discarded (pointers cleared) immediately; the memory array itself is not required to be cleared.
- No state machine beyond the synchronizer/edge detector and the pointer logic. Write path states: WAIT_HIGH (sync=0) → WRITE (one cycle) → WAIT_LOW (sync=1) → WAIT_HIGH when sync returns to 0.

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN
- Defined:
  - Adds output TimeoutIrq (1 bit) and a 16-bit idle counter.
  - The counter resets to 0 on any accepted write, on any read, or while Empty.
  - Otherwise it increments each Clk, saturating at TIMEOUT_CYCLES.
  - TimeoutIrq=1 while counter == TIMEOUT_CYCLES and not Empty, so the host can drain partial bursts.
  - TimeoutIrq clears the cycle after the next read or write.
- Undefined: no TimeoutIrq port, no counter logic.

Test Plan:
- Reset, then RxData=8'hA5 with RxDone held high 40 cycles → exactly one write; Count=1 and Empty=0 on cycle 4 after the rise; RdEn one cycle → RdData=8'hA5, RdValid=1 next cycle, Empty=1.
- 16 frames 8'h00..8'h0F → Full=1, Count=16; a 17th frame 8'hFF → Overflow=1 and Count stays 16; drain 16 reads → 8'h00..8'h0F in order; OvfClr → Overflow=0.
- FIFO full, and wr_req coincides with RdEn → Count stays 16, Overflow stays 0, the new byte is read last.
- RdEn held with FIFO empty for 10 cycles → RdValid never asserts, pointers unchanged.
- 20 writes/reads interleaved across pointer wrap (write 10, read 10, write 10, read 10) → data in order, Count correct at each step.
- With UART_RX_FIFO_TIMEOUT_EN and TIMEOUT_CYCLES=100: one byte written, no reads → TimeoutIrq rises exactly 100 Clk after the write; a read clears it. Also, asserting Rst_n low mid-burst → Empty=1 and Count=0 immediately.
